// File: rtl/wb_stream_arb.sv
// rtl/wb_stream_arb.sv - two-channel round-robin Wishbone arbiter with per-transfer watchdog
module wb_stream_arb #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WB_AW-1:0]   ch0_adr_i,
  input  logic [WB_DW-1:0]   ch0_dat_i,
  input  logic [WB_DW/8-1:0] ch0_sel_i,
  input  logic               ch0_we_i,
  input  logic               ch0_cyc_i,
  input  logic               ch0_stb_i,
  input  logic [2:0]         ch0_cti_i,
  input  logic [1:0]         ch0_bte_i,
  output logic [WB_DW-1:0]   ch0_dat_o,
  output logic               ch0_ack_o,
  output logic               ch0_err_o,
  output logic               ch0_rty_o,
  input  logic [WB_AW-1:0]   ch1_adr_i,
  input  logic [WB_DW-1:0]   ch1_dat_i,
  input  logic [WB_DW/8-1:0] ch1_sel_i,
  input  logic               ch1_we_i,
  input  logic               ch1_cyc_i,
  input  logic               ch1_stb_i,
  input  logic [2:0]         ch1_cti_i,
  input  logic [1:0]         ch1_bte_i,
  output logic [WB_DW-1:0]   ch1_dat_o,
  output logic               ch1_ack_o,
  output logic               ch1_err_o,
  output logic               ch1_rty_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  output logic [1:0]         grant_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_t          state;
  logic            last;
  logic [TO_W-1:0] wd_cnt;

  logic granted;
  logic use_ch1;
  logic own_cyc;
  logic own_stb;
  logic waiting;
  logic wd_hit;

  // `last` doubles as the current owner: it is loaded on every grant and held through ABORT.
  assign granted = (state == GNT0) || (state == GNT1);
  assign use_ch1 = (state != IDLE) && last;
  assign own_cyc = use_ch1 ? ch1_cyc_i : ch0_cyc_i;
  assign own_stb = use_ch1 ? ch1_stb_i : ch0_stb_i;

  assign wbm_adr_o = use_ch1 ? ch1_adr_i : ch0_adr_i;
  assign wbm_dat_o = use_ch1 ? ch1_dat_i : ch0_dat_i;
  assign wbm_sel_o = use_ch1 ? ch1_sel_i : ch0_sel_i;
  assign wbm_we_o  = use_ch1 ? ch1_we_i  : ch0_we_i;
  assign wbm_cti_o = use_ch1 ? ch1_cti_i : ch0_cti_i;
  assign wbm_bte_o = use_ch1 ? ch1_bte_i : ch0_bte_i;
  assign wbm_cyc_o = granted && own_cyc;
  assign wbm_stb_o = granted && own_stb && own_cyc;

  assign ch0_dat_o = wbm_dat_i;
  assign ch1_dat_o = wbm_dat_i;

  assign ch0_ack_o = (state == GNT0) && wbm_ack_i;
  assign ch1_ack_o = (state == GNT1) && wbm_ack_i;
  assign ch0_rty_o = (state == GNT0) && wbm_rty_i;
  assign ch1_rty_o = (state == GNT1) && wbm_rty_i;
  // timeout_o is high only in the first ABORT cycle, so it also gates the injected ERR.
  assign ch0_err_o = ((state == GNT0) && wbm_err_i) || ((state == ABORT) && !last && timeout_o);
  assign ch1_err_o = ((state == GNT1) && wbm_err_i) || ((state == ABORT) && last && timeout_o);

  assign grant_o = (state == IDLE) ? 2'b00 : (last ? 2'b10 : 2'b01);

  assign waiting = wbm_stb_o && !wbm_ack_i && !wbm_err_i && !wbm_rty_i;
  assign wd_hit  = (TIMEOUT != 0) && waiting && (wd_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      wd_cnt    <= '0;
      case (state)
        IDLE: begin
          if (ch0_cyc_i && (!ch1_cyc_i || last)) begin
            state <= GNT0;
            last  <= 1'b0;
          end else if (ch1_cyc_i) begin
            state <= GNT1;
            last  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!own_cyc) begin
            state <= IDLE;
          end else if (wd_hit) begin
            state     <= ABORT;
            timeout_o <= 1'b1;
          end else if (waiting) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ABORT: begin
          if (!own_cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stream_arb.sv
// tb/tb_wb_stream_arb.sv - directed self-checking bench for wb_stream_arb
module tb_wb_stream_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ch0_adr_i = '0, ch1_adr_i = '0, wbm_adr_o;
  logic [DW-1:0] ch0_dat_i = '0, ch1_dat_i = '0, ch0_dat_o, ch1_dat_o, wbm_dat_o, wbm_dat_i = '0;
  logic [3:0]    ch0_sel_i = 4'hf, ch1_sel_i = 4'hf, wbm_sel_o;
  logic          ch0_we_i = 0, ch1_we_i = 0, wbm_we_o;
  logic          ch0_cyc_i = 0, ch1_cyc_i = 0, wbm_cyc_o;
  logic          ch0_stb_i = 0, ch1_stb_i = 0, wbm_stb_o;
  logic [2:0]    ch0_cti_i = '0, ch1_cti_i = '0, wbm_cti_o;
  logic [1:0]    ch0_bte_i = '0, ch1_bte_i = '0, wbm_bte_o;
  logic          ch0_ack_o, ch0_err_o, ch0_rty_o, ch1_ack_o, ch1_err_o, ch1_rty_o;
  logic          wbm_ack_i = 0, wbm_err_i = 0, wbm_rty_i = 0;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  wb_stream_arb #(.WB_AW(AW), .WB_DW(DW), .TIMEOUT(8), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .ch0_adr_i(ch0_adr_i), .ch0_dat_i(ch0_dat_i), .ch0_sel_i(ch0_sel_i), .ch0_we_i(ch0_we_i),
    .ch0_cyc_i(ch0_cyc_i), .ch0_stb_i(ch0_stb_i), .ch0_cti_i(ch0_cti_i), .ch0_bte_i(ch0_bte_i),
    .ch0_dat_o(ch0_dat_o), .ch0_ack_o(ch0_ack_o), .ch0_err_o(ch0_err_o), .ch0_rty_o(ch0_rty_o),
    .ch1_adr_i(ch1_adr_i), .ch1_dat_i(ch1_dat_i), .ch1_sel_i(ch1_sel_i), .ch1_we_i(ch1_we_i),
    .ch1_cyc_i(ch1_cyc_i), .ch1_stb_i(ch1_stb_i), .ch1_cti_i(ch1_cti_i), .ch1_bte_i(ch1_bte_i),
    .ch1_dat_o(ch1_dat_o), .ch1_ack_o(ch1_ack_o), .ch1_err_o(ch1_err_o), .ch1_rty_o(ch1_rty_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    ch0_cyc_i = 0; ch0_stb_i = 0; ch1_cyc_i = 0; ch1_stb_i = 0;
    wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  int beat[2];
  int drop[2];
  int order[$];
  int own;

  initial begin
    // Reset state
    do_reset;
    settle;
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_grant", grant_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_resp", {ch0_ack_o, ch0_err_o, ch0_rty_o, ch1_ack_o, ch1_err_o, ch1_rty_o}, 0);

    // Single read on ch0, ACK on the third bus cycle
    tick;
    ch0_cyc_i = 1; ch0_stb_i = 1; ch0_adr_i = 32'h100; ch0_cti_i = 3'b000;
    settle;
    check("single_no_cyc_yet", wbm_cyc_o, 0);
    tick;
    settle;
    check("single_cyc", wbm_cyc_o, 1);
    check("single_adr", wbm_adr_o, 32'h100);
    check("single_grant", grant_o, 2'b01);
    check("single_ack_early", ch0_ack_o, 0);
    tick;
    settle;
    check("single_ack_wait", ch0_ack_o, 0);
    tick;
    wbm_ack_i = 1; wbm_dat_i = 32'hdeadbeef;
    settle;
    check("single_ack0", ch0_ack_o, 1);
    check("single_ack1", ch1_ack_o, 0);
    check("single_dat0", ch0_dat_o, 32'hdeadbeef);
    check("single_dat1", ch1_dat_o, 32'hdeadbeef);
    tick;
    wbm_ack_i = 0; ch0_cyc_i = 0; ch0_stb_i = 0;
    settle;
    check("single_release_cyc", wbm_cyc_o, 0);
    check("single_release_grant", grant_o, 2'b01);
    tick;
    settle;
    check("single_idle_grant", grant_o, 2'b00);

    // Simultaneous request after reset: ch0 first, one IDLE cycle, then ch1
    do_reset;
    ch0_cyc_i = 1; ch0_stb_i = 1; ch0_adr_i = 32'h200;
    ch1_cyc_i = 1; ch1_stb_i = 1; ch1_adr_i = 32'h300;
    settle;
    check("tie_idle", grant_o, 2'b00);
    tick;
    wbm_ack_i = 1;
    settle;
    check("tie_first", grant_o, 2'b01);
    check("tie_adr0", wbm_adr_o, 32'h200);
    check("tie_ack0", ch0_ack_o, 1);
    check("tie_ack1", ch1_ack_o, 0);
    tick;
    wbm_ack_i = 0; ch0_cyc_i = 0; ch0_stb_i = 0;
    settle;
    check("tie_drop_cyc", wbm_cyc_o, 0);
    tick;
    settle;
    check("tie_gap", grant_o, 2'b00);
    check("tie_gap_cyc", wbm_cyc_o, 0);
    tick;
    wbm_err_i = 1;
    settle;
    check("tie_second", grant_o, 2'b10);
    check("tie_adr1", wbm_adr_o, 32'h300);
    check("tie_err1", ch1_err_o, 1);
    check("tie_err0", ch0_err_o, 0);
    tick;
    wbm_err_i = 0; ch1_cyc_i = 0; ch1_stb_i = 0;
    tick;

    // Sustained contention with 4-beat incrementing bursts
    beat[0] = 0; beat[1] = 0; drop[0] = 0; drop[1] = 0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      ch0_cyc_i = (drop[0] == 0); ch0_stb_i = (drop[0] == 0);
      ch0_cti_i = (beat[0] == 3) ? 3'b111 : 3'b010;
      ch0_adr_i = 32'h1000 + 32'(beat[0] * 4);
      ch1_cyc_i = (drop[1] == 0); ch1_stb_i = (drop[1] == 0);
      ch1_cti_i = (beat[1] == 3) ? 3'b111 : 3'b010;
      ch1_adr_i = 32'h2000 + 32'(beat[1] * 4);
      wbm_ack_i = 0;
      settle;
      own = -1;
      if (grant_o == 2'b01 && drop[0] == 0) own = 0;
      if (grant_o == 2'b10 && drop[1] == 0) own = 1;
      if (own >= 0) begin
        check("cont_cyc", wbm_cyc_o, 1);
        check("cont_cti", wbm_cti_o, (beat[own] == 3) ? 3'b111 : 3'b010);
        check("cont_adr", wbm_adr_o, (own == 0 ? 32'h1000 : 32'h2000) + 32'(beat[own] * 4));
        wbm_ack_i = 1;
        #1;
        check("cont_ack_own", own == 0 ? ch0_ack_o : ch1_ack_o, 1);
        check("cont_ack_other", own == 0 ? ch1_ack_o : ch0_ack_o, 0);
        beat[own]++;
        if (beat[own] == 4) begin
          beat[own] = 0;
          drop[own] = 2;
          order.push_back(own);
        end
      end else if (grant_o != 2'b00) begin
        check("cont_drop_cyc", wbm_cyc_o, 0);
      end
      for (int n = 0; n < 2; n++) if (drop[n] > 0) drop[n]--;
      tick;
    end
    wbm_ack_i = 0;
    check("cont_bursts", order.size(), 4);
    for (int k = 0; k < order.size(); k++) check("cont_order", order[k], k % 2);
    ch0_cyc_i = 0; ch0_stb_i = 0; ch1_cyc_i = 0; ch1_stb_i = 0;
    tick;
    tick;

    // Watchdog abort on ch1, ERR in the 9th STB cycle
    do_reset;
    ch1_cyc_i = 1; ch1_stb_i = 1; ch1_adr_i = 32'h400;
    tick;
    for (int k = 1; k <= 8; k++) begin
      settle;
      check("to_wait_err", ch1_err_o, 0);
      check("to_wait_pulse", timeout_o, 0);
      check("to_wait_cyc", wbm_cyc_o, 1);
      tick;
    end
    settle;
    check("to_err1", ch1_err_o, 1);
    check("to_err0", ch0_err_o, 0);
    check("to_pulse", timeout_o, 1);
    check("to_cyc", wbm_cyc_o, 0);
    check("to_grant", grant_o, 2'b10);
    tick;
    settle;
    check("to_err_once", ch1_err_o, 0);
    check("to_pulse_once", timeout_o, 0);
    check("to_cyc_held", wbm_cyc_o, 0);
    check("to_grant_held", grant_o, 2'b10);
    tick;
    ch1_cyc_i = 0; ch1_stb_i = 0;
    settle;
    check("to_grant_abort", grant_o, 2'b10);
    tick;
    settle;
    check("to_grant_idle", grant_o, 2'b00);

    // ACK on the timeout boundary clears the counter; a later stall of 8 cycles aborts
    ch0_cyc_i = 1; ch0_stb_i = 1; ch0_adr_i = 32'h500;
    tick;
    for (int k = 1; k <= 17; k++) begin
      wbm_ack_i = (k == 8);
      settle;
      if (k == 8) check("bnd_ack", ch0_ack_o, 1);
      if (k < 17) begin
        check("bnd_no_pulse", timeout_o, 0);
        check("bnd_no_err", ch0_err_o, 0);
      end else begin
        check("bnd_late_pulse", timeout_o, 1);
        check("bnd_late_err", ch0_err_o, 1);
        check("bnd_late_cyc", wbm_cyc_o, 0);
      end
      tick;
    end
    wbm_ack_i = 0; ch0_cyc_i = 0; ch0_stb_i = 0;
    tick;
    tick;

    // Reset mid-burst; ch0 must still win the first tie afterwards
    ch0_cyc_i = 1; ch0_stb_i = 1; ch0_cti_i = 3'b010; ch0_adr_i = 32'h600;
    tick;
    wbm_ack_i = 1;
    settle;
    check("rmb_grant", grant_o, 2'b01);
    tick;
    wbm_ack_i = 0; rst = 1; ch0_adr_i = 32'h604;
    tick;
    rst = 0; ch1_cyc_i = 1; ch1_stb_i = 1;
    settle;
    check("rmb_cyc", wbm_cyc_o, 0);
    check("rmb_grant_none", grant_o, 2'b00);
    check("rmb_no_err", ch0_err_o, 0);
    check("rmb_no_pulse", timeout_o, 0);
    tick;
    settle;
    check("rmb_first", grant_o, 2'b01);
    check("rmb_cyc_again", wbm_cyc_o, 1);
    ch0_cyc_i = 0; ch0_stb_i = 0; ch1_cyc_i = 0; ch1_stb_i = 0;
    tick;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
